ysyx_2022040010_mem_arbiter: RTL and testbench
==============================================

# ysyx_2022040010_mem_arbiter

Two-requester arbiter and sequencer that shares one variable-latency memory port between the core's instruction-fetch path and its load/store path. It sits between the core's isram/dsram interfaces and the single downstream memory. Requests are granted one at a time: data has priority, with a starvation guard for fetch and a watchdog that aborts hung transactions.

## Interface
- MAX_D_STREAK, 4: consecutive data grants allowed while a fetch is pending before fetch is forced next (≥1).
- TIMEOUT, 255: cycles in BUSY without mem_ack before abort (≥1, 8-bit counter).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_done.
- if_addr  in  64  fetch address; bit 2 selects 32-bit half of mem_rdata.
- if_done  out  1  one-cycle completion pulse.
- if_err  out  1  valid with if_done; 1 = timed out.
- if_rdata  out  32  instruction; valid with if_done, 0 on error.
- d_req  in  1  data request; payload held stable until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 byte, 01 half, 10 word, 11 dword.
- d_addr  in  64  data address.
- d_wdata  in  64  store data (software-aligned by size).
- d_done  out  1  one-cycle completion pulse.
- d_err  out  1  valid with d_done; 1 = timed out.
- d_rdata  out  64  load data; valid with d_done, 0 on error or store.
- mem_req  out  1  downstream request; held until mem_ack or abort.
- mem_we, mem_size, mem_addr, mem_wdata  out  1/2/64/64  registered payload of granted requester (fetch: we=0, size=10).
- mem_ack  in  1  downstream completion; mem_rdata valid same cycle.
- mem_rdata  in  64  downstream read data.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: no request → stay. Only d_req → BUSY_D. Only if_req → BUSY_I. Both → BUSY_D unless streak == MAX_D_STREAK, then BUSY_I. On grant, payload registered onto mem_* and mem_req asserted.
- Streak counter: +1 on each data grant while if_req high (saturates at MAX_D_STREAK); cleared on fetch grant or whenever if_req low in IDLE.
- BUSY_x: mem_req=1, watchdog counts. mem_ack → capture rdata (fetch: mem_rdata[63:32] if if_addr[2] else [31:0]), err=0, → RESP. Watchdog reaches TIMEOUT with no ack → drop mem_req, rdata=0, err=1, → RESP. Ack in the same cycle as timeout: ack wins, err=0.
- RESP: owner's done=1 for exactly one cycle; requests ignored; → IDLE. Requester may deassert or present a new request from the cycle after done.
- mem_ack outside BUSY is ignored. Non-owner's done never pulses.
- Reset: state IDLE, mem_req=0, all done/err=0, rdata outputs 0, mem_* payload 0, streak and watchdog 0. Reset mid-transaction aborts silently (no done pulse); a late mem_ack after reset is ignored.

## Timing
- Request seen in IDLE at cycle 0 → mem_req=1 from cycle 1; mem_ack at cycle 1+w (w ≥ 0) → done at cycle 2+w → IDLE at 3+w. Minimum request-to-done latency 2 cycles, minimum issue interval 3 cycles.
- Timeout: mem_req high for cycles 1..TIMEOUT, low at TIMEOUT+1, done+err at TIMEOUT+1.
- All outputs registered; no combinational path from any input to any output.

## Structure
- Shared defines (defines.v): state encodings, d_size codes (SIZE_B/H/W/D), fetch size constant.
- One sub-module: ysyx_2022040010_wdt — load-clear 8-bit watchdog counter with enable and expire flag at TIMEOUT.

## Test plan
- Single fetch, if_addr=0x8000_0004, mem_ack w=2, mem_rdata=0x1111_2222_3333_4444 → if_done at cycle 4, if_rdata=0x1111_2222, if_err=0.
- Simultaneous if_req and d_req (load 0x8000_1000, size 11) in IDLE → data granted first; fetch issued at cycle 3 after d_done.
- d_req held continuously with if_req pending, MAX_D_STREAK=4 → grant order D,D,D,D,I,D…
- Store (d_we=1, size 00, wdata=0xAB) → mem_we=1, mem_size=00, mem_wdata=0xAB; d_rdata=0.
- No mem_ack, TIMEOUT=8 → mem_req drops cycle 9, d_done=1 and d_err=1 at cycle 9; ack at cycle 8 instead → err=0.
- rst asserted during BUSY_I → next cycle mem_req=0, no if_done; subsequent mem_ack ignored; new d_req serviced normally.

Source files
------------

// File: rtl/ysyx_2022040010_mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Includes the arbiter state encoding, the access-size codes and the fetch lane select.
package ysyx_2022040010_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    localparam logic [1:0] SIZE_B     = 2'b00;
    localparam logic [1:0] SIZE_H     = 2'b01;
    localparam logic [1:0] SIZE_W     = 2'b10;
    localparam logic [1:0] SIZE_D     = 2'b11;
    localparam logic [1:0] FETCH_SIZE = SIZE_W;

    // Instructions are 32 bits wide; address bit 2 picks the upper or lower half of the 64-bit beat.
    function automatic logic [31:0] fetch_word(input logic [63:0] rdata, input logic hi);
        return hi ? rdata[63:32] : rdata[31:0];
    endfunction

endpackage

// File: rtl/ysyx_2022040010_mem_arbiter_wdt.sv
// 8-bit transaction watchdog: cleared between transactions, counts busy cycles,
// and flags expiry on the TIMEOUT-th busy cycle.
module ysyx_2022040010_wdt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;
    logic       w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign o_expire  = i_en && w_at_last;

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_at_last) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/ysyx_2022040010_mem_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and load/store.
// Data has priority, fetch gets a starvation guard, and a watchdog aborts hung accesses.
module ysyx_2022040010_mem_arbiter
    import ysyx_2022040010_mem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_done,
    output logic        if_err,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_done,
    output logic        d_err,
    output logic [63:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    localparam int SW = (MAX_D_STREAK < 2) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_e  r_state;
    logic [SW-1:0] r_streak;
    logic        r_if_done, r_if_err, r_d_done, r_d_err;
    logic [31:0] r_if_rdata;
    logic [63:0] r_d_rdata;
    logic        r_mem_req, r_mem_we;
    logic [1:0]  r_mem_size;
    logic [63:0] r_mem_addr, r_mem_wdata;

    logic w_busy, w_expire, w_grant_d;

    assign w_busy    = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);
    // Data wins unless fetch has already waited out a full streak of data grants.
    assign w_grant_d = d_req && !(if_req && (r_streak == STREAK_MAX));

    ysyx_2022040010_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (!w_busy),
        .i_en     (w_busy),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_streak    <= '0;
            r_if_done   <= 1'b0;
            r_if_err    <= 1'b0;
            r_if_rdata  <= '0;
            r_d_done    <= 1'b0;
            r_d_err     <= 1'b0;
            r_d_rdata   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_size  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!if_req) r_streak <= '0;
                    if (w_grant_d) begin
                        r_state     <= ST_BUSY_D;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_size  <= d_size;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        if (if_req && (r_streak != STREAK_MAX)) r_streak <= r_streak + SW'(1);
                    end else if (if_req) begin
                        r_state     <= ST_BUSY_I;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_size  <= FETCH_SIZE;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                        r_streak    <= '0;
                    end
                end
                ST_BUSY_I: begin
                    // An ack arriving on the expiry cycle still completes successfully.
                    if (mem_ack || w_expire) begin
                        r_state    <= ST_RESP;
                        r_mem_req  <= 1'b0;
                        r_if_done  <= 1'b1;
                        r_if_err   <= !mem_ack;
                        r_if_rdata <= mem_ack ? fetch_word(mem_rdata, r_mem_addr[2]) : '0;
                    end
                end
                ST_BUSY_D: begin
                    if (mem_ack || w_expire) begin
                        r_state   <= ST_RESP;
                        r_mem_req <= 1'b0;
                        r_d_done  <= 1'b1;
                        r_d_err   <= !mem_ack;
                        r_d_rdata <= (mem_ack && !r_mem_we) ? mem_rdata : '0;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign if_done   = r_if_done;
    assign if_err    = r_if_err;
    assign if_rdata  = r_if_rdata;
    assign d_done    = r_d_done;
    assign d_err     = r_d_err;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_size  = r_mem_size;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_ysyx_2022040010_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized contention against a transaction-level model.
module tb_ysyx_2022040010_mem_arbiter;

    localparam int TO   = 8;
    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_done, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [1:0]  d_size;
    logic [63:0] d_addr, d_wdata;
    logic        d_done, d_err;
    logic [63:0] d_rdata;
    logic        mem_req, mem_we;
    logic [1:0]  mem_size;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int streak_m = 0;
    bit was_d;
    bit [5:0] order;

    always #5 clk = ~clk;

    ysyx_2022040010_mem_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input logic [63:0] a);
        if_req  = 1'b1;
        if_addr = a;
    endtask

    task automatic set_data(input logic we, input logic [1:0] sz, input logic [63:0] a, input logic [63:0] wd);
        d_req   = 1'b1;
        d_we    = we;
        d_size  = sz;
        d_addr  = a;
        d_wdata = wd;
    endtask

    // One arbitration round starting from an IDLE cycle (cycle 0) with the current requests.
    task automatic run_txn(input int w, input logic [63:0] rd, input bit timeout, input bit keep_d,
                           output bit granted_d);
        bit gd;
        logic [63:0] exp_if, exp_d;
        gd = d_req && !(if_req && streak_m >= MAXS);
        if (!if_req) streak_m = 0;
        if (gd) begin
            if (if_req && streak_m < MAXS) streak_m = streak_m + 1;
        end else begin
            streak_m = 0;
        end
        tick();
        chk("mem_req_issue", mem_req, 1);
        chk("mem_we", mem_we, gd ? d_we : 1'b0);
        chk("mem_size", mem_size, gd ? d_size : 2'b10);
        chk("mem_addr", mem_addr, gd ? d_addr : if_addr);
        chk("mem_wdata", mem_wdata, gd ? d_wdata : 64'd0);
        if (timeout) begin
            repeat (TO - 1) tick();
            chk("mem_req_last_wait", mem_req, 1);
            tick();
        end else begin
            repeat (w) tick();
            mem_rdata = rd;
            mem_ack   = 1'b1;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = {$urandom, $urandom};
        end
        exp_if = (if_addr % 8 >= 4) ? (rd >> 32) : (rd & 64'hFFFF_FFFF);
        exp_d  = d_we ? 64'd0 : rd;
        chk("mem_req_dropped", mem_req, 0);
        chk("d_done", d_done, gd);
        chk("if_done", if_done, !gd);
        if (gd) begin
            chk("d_err", d_err, timeout);
            chk("d_rdata", d_rdata, timeout ? 64'd0 : exp_d);
        end else begin
            chk("if_err", if_err, timeout);
            chk("if_rdata", if_rdata, timeout ? 64'd0 : exp_if);
        end
        tick();
        chk("done_one_cycle", {62'd0, if_done, d_done}, 64'd0);
        granted_d = gd;
        if (gd && !keep_d) d_req = 1'b0;
        if (!gd) if_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        streak_m = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=expired expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_size = '0;
        d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        do_reset();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_dones", {62'd0, if_done, d_done}, 64'd0);
        chk("rst_errs", {62'd0, if_err, d_err}, 64'd0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_payload", mem_addr | mem_wdata | {61'd0, mem_we, mem_size}, 64'd0);

        // Single fetch, upper half, ack after two wait cycles.
        set_fetch(64'h8000_0004);
        run_txn(2, 64'h1111_2222_3333_4444, 1'b0, 1'b0, was_d);

        // Simultaneous requests: data first, fetch immediately after.
        set_fetch(64'h8000_0100);
        set_data(1'b0, 2'b11, 64'h8000_1000, 64'd0);
        run_txn(0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0, was_d);
        chk("first_grant_data", was_d, 1);
        run_txn(1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, was_d);
        chk("second_grant_fetch", was_d, 0);

        // Store of a single byte returns zero read data.
        set_data(1'b1, 2'b00, 64'h8000_2003, 64'hAB);
        run_txn(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, was_d);

        // Watchdog abort, then ack exactly on the expiry cycle.
        set_data(1'b0, 2'b10, 64'h8000_3000, 64'd0);
        run_txn(0, 64'h5555_AAAA_5555_AAAA, 1'b1, 1'b0, was_d);
        set_data(1'b0, 2'b10, 64'h8000_3008, 64'd0);
        run_txn(TO - 1, 64'h7777_8888_9999_0000, 1'b0, 1'b0, was_d);

        // Starvation guard: data held continuously while fetch waits.
        do_reset();
        set_fetch(64'h8000_0000);
        set_data(1'b0, 2'b11, 64'h8000_4000, 64'd0);
        for (int k = 0; k < 6; k++) begin
            run_txn(k % 3, {$urandom, $urandom}, 1'b0, 1'b1, was_d);
            order[k] = was_d;
        end
        chk("grant_order", order, 64'b101111);
        d_req = 1'b0;

        // Reset in the middle of a fetch aborts silently and ignores a late ack.
        set_fetch(64'h8000_0008);
        tick();
        chk("busy_before_rst", mem_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        streak_m = 0;
        chk("rst_mid_mem_req", mem_req, 0);
        chk("rst_mid_no_done", if_done, 0);
        if_req    = 1'b0;
        mem_rdata = 64'h1234_5678_9ABC_DEF0;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
        chk("late_ack_mem_req", mem_req, 0);
        tick();
        chk("late_ack_no_done", {62'd0, if_done, d_done}, 64'd0);
        set_data(1'b0, 2'b01, 64'h8000_5002, 64'd0);
        run_txn(1, 64'h0000_0000_0000_BEEF, 1'b0, 1'b0, was_d);

        // Randomized contention against the transaction-level model.
        for (int k = 0; k < 40; k++) begin
            if (!if_req && ($urandom % 2 == 0)) set_fetch({$urandom, $urandom});
            if (!d_req && ($urandom % 2 == 0))
                set_data(1'($urandom), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            if (!if_req && !d_req) set_fetch({$urandom, $urandom});
            run_txn(int'($urandom % 4), {$urandom, $urandom}, ($urandom % 10 == 0), 1'b0, was_d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
